// File: rtl/cpu_step_if.sv
// Key/mode/config inputs and enable/status outputs of cpu_step_ctrl.
// master drives the controls, slave is the controller itself.
interface cpu_step_if #(
    parameter int BURST_W = 8,
    parameter int DIV_W   = 26,
    parameter int CNT_W   = 16
);
    logic               step_key_n;
    logic [1:0]         mode;
    logic [BURST_W-1:0] burst_len;
    logic [DIV_W-1:0]   run_div;
    logic               cpu_en;
    logic               busy;
    logic [CNT_W-1:0]   step_count;

    modport master (
        output step_key_n, mode, burst_len, run_div,
        input  cpu_en, busy, step_count
    );

    modport slave (
        input  step_key_n, mode, burst_len, run_div,
        output cpu_en, busy, step_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: debounced key drives step, burst,
// free-run and halt modes; counts every enable pulse issued.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int BURST_W         = 8,
    parameter int DIV_W           = 26,
    parameter int CNT_W           = 16
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    cpu_step_if.slave  bus
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_LAST =
        DBW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] M_STEP  = 2'b00;
    localparam logic [1:0] M_BURST = 2'b01;
    localparam logic [1:0] M_RUN   = 2'b10;
    localparam logic [1:0] M_HALT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RUN   = 2'd2
    } state_t;

    logic               sync1, sync2;
    logic               db_level, db_prev;
    logic [DBW-1:0]     db_cnt;
    logic               press;

    state_t             state, state_n;
    logic [BURST_W-1:0] burst_rem, rem_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic               en_n;
    logic               cpu_en_q, busy_q;
    logic [CNT_W-1:0]   count_q;

    // Level is accepted only after a full run of differing samples.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            db_level <= 1'b1;
            db_prev  <= 1'b1;
            db_cnt   <= '0;
        end else begin
            sync1   <= bus.step_key_n;
            sync2   <= sync1;
            db_prev <= db_level;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end
    end

    assign press = db_prev & ~db_level;

    always_comb begin
        state_n = state;
        rem_n   = burst_rem;
        div_n   = div_cnt;
        en_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mode == M_RUN) begin
                    state_n = RUN;
                    div_n   = bus.run_div;
                end else if (press && bus.mode == M_BURST) begin
                    state_n = BURST;
                    rem_n   = (bus.burst_len == '0) ?
                              BURST_W'(1) : bus.burst_len;
                end else if (press && bus.mode == M_STEP) begin
                    en_n = 1'b1;
                end
            end
            BURST: begin
                if (bus.mode == M_HALT) begin
                    state_n = IDLE;
                end else begin
                    en_n  = 1'b1;
                    rem_n = burst_rem - BURST_W'(1);
                    if (burst_rem == BURST_W'(1))
                        state_n = IDLE;
                end
            end
            RUN: begin
                // A pulse due this cycle still goes out on exit.
                if (div_cnt == '0) begin
                    en_n  = 1'b1;
                    div_n = bus.run_div;
                end else begin
                    div_n = div_cnt - DIV_W'(1);
                end
                if (bus.mode != M_RUN)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            burst_rem <= '0;
            div_cnt   <= '0;
            cpu_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state     <= state_n;
            burst_rem <= rem_n;
            div_cnt   <= div_n;
            cpu_en_q  <= en_n;
            busy_q    <= (state != IDLE);
            count_q   <= count_q + CNT_W'(cpu_en_q);
        end
    end

    assign bus.cpu_en     = cpu_en_q;
    assign bus.busy       = busy_q;
    assign bus.step_count = count_q;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: scenario table, corner sequences and
// random stimulus against a pulse-level reference model.
module tb_cpu_step_ctrl;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        key_n = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  blen = 8'd0;
    logic [25:0] rdiv = 26'd0;

    always #5 clk = ~clk;

    cpu_step_if #(.BURST_W(8), .DIV_W(26), .CNT_W(16)) b16 ();
    cpu_step_if #(.BURST_W(8), .DIV_W(26), .CNT_W(4))  b4 ();

    assign b16.step_key_n = key_n;
    assign b16.mode       = mode;
    assign b16.burst_len  = blen;
    assign b16.run_div    = rdiv;
    assign b4.step_key_n  = key_n;
    assign b4.mode        = mode;
    assign b4.burst_len   = blen;
    assign b4.run_div     = rdiv;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DC), .BURST_W(8), .DIV_W(26), .CNT_W(16)
    ) dut (.CLOCK_50(clk), .resetn(resetn), .bus(b16.slave));

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(DC), .BURST_W(8), .DIV_W(26), .CNT_W(4)
    ) dut4 (.CLOCK_50(clk), .resetn(resetn), .bus(b4.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            if (n_bad < 30)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         nm, act, exp, $time);
            n_bad++;
        end
    endtask

    // Reference model: key history window, pulse budgets and a
    // countdown to the next free-run pulse.
    logic [1:0]  kh = 2'b11;
    logic [DC-1:0] hist = '1;
    logic        lvl = 1'b1;
    logic        press_f = 1'b0;
    int          burst_left = 0;
    bit          running = 0;
    int          wait_c = 0;
    logic        exp_en = 1'b0;
    logic        exp_busy = 1'b0;
    int unsigned exp_cnt = 0;

    task automatic model_step();
        bit   active, press, en_next;
        logic synced;
        if (!resetn) begin
            kh = 2'b11; hist = '1; lvl = 1'b1; press_f = 1'b0;
            burst_left = 0; running = 0; wait_c = 0;
            exp_en = 1'b0; exp_busy = 1'b0; exp_cnt = 0;
            return;
        end
        active  = (burst_left > 0) || running;
        press   = press_f;
        en_next = 0;
        exp_cnt = exp_cnt + int'(exp_en);
        if (burst_left > 0) begin
            if (mode == 2'b11) begin
                burst_left = 0;
            end else begin
                en_next = 1;
                burst_left--;
            end
        end else if (running) begin
            if (wait_c == 0) begin
                en_next = 1;
                wait_c = int'(rdiv);
            end else begin
                wait_c--;
            end
            if (mode != 2'b10) running = 0;
        end else if (mode == 2'b10) begin
            running = 1;
            wait_c  = int'(rdiv);
        end else if (press && mode == 2'b01) begin
            burst_left = (blen == 0) ? 1 : int'(blen);
        end else if (press && mode == 2'b00) begin
            en_next = 1;
        end
        exp_en   = en_next;
        exp_busy = active;
        synced   = kh[1];
        kh       = {kh[0], key_n};
        hist     = {hist[DC-2:0], synced};
        press_f  = 1'b0;
        if (hist == {DC{~lvl}}) begin
            press_f = lvl;
            lvl     = ~lvl;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge resetn);
        model_step();
    end

    int pulse_seen = 0;
    int busy_seen  = 0;

    initial forever begin
        logic [15:0] e16;
        logic [3:0]  e4;
        @(negedge clk);
        e16 = exp_cnt[15:0];
        e4  = exp_cnt[3:0];
        chk("cpu_en", b16.cpu_en, exp_en);
        chk("busy", b16.busy, exp_busy);
        chk("step_count", b16.step_count, e16);
        chk("cpu_en_w4", b4.cpu_en, exp_en);
        chk("step_count_w4", b4.step_count, e4);
        if (b16.cpu_en) pulse_seen++;
        if (b16.busy)   busy_seen++;
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_pulse(int bound, output int k);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!b16.cpu_en && k < bound);
    endtask

    task automatic do_reset(int n);
        @(posedge clk); #2;
        resetn = 1'b0;
        cyc(n);
        resetn = 1'b1;
    endtask

    typedef struct {
        string      nm;
        logic [1:0] md;
        logic [7:0] bl;
        int         hold;
        int         pulses;
        int         busy;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int p0, b0, k, ones;
        vecs.push_back('{"step_hold",   2'b00, 8'd0, 10, 1, 0});
        vecs.push_back('{"step_bounce", 2'b00, 8'd0,  2, 0, 0});
        vecs.push_back('{"burst5",      2'b01, 8'd5, 10, 5, 5});
        vecs.push_back('{"burst0",      2'b01, 8'd0, 10, 1, 1});
        vecs.push_back('{"burst1",      2'b01, 8'd1, 10, 1, 1});
        vecs.push_back('{"burst3_held", 2'b01, 8'd3, 40, 3, 3});
        vecs.push_back('{"halt_press",  2'b11, 8'd9, 10, 0, 0});
        vecs.push_back('{"step_again",  2'b00, 8'd7, 12, 1, 0});

        cyc(3);
        resetn = 1'b1;
        #1;
        chk("reset_count", b16.step_count, 0);
        chk("reset_busy", b16.busy, 0);
        cyc(4);

        foreach (vecs[i]) begin
            mode = vecs[i].md;
            blen = vecs[i].bl;
            p0 = pulse_seen;
            b0 = busy_seen;
            key_n = 1'b0;
            cyc(vecs[i].hold);
            key_n = 1'b1;
            cyc(20);
            chk({vecs[i].nm, "_pulses"}, pulse_seen - p0,
                vecs[i].pulses);
            chk({vecs[i].nm, "_busy"}, busy_seen - b0,
                vecs[i].busy);
        end

        // Second press lands mid-burst and must not queue.
        mode = 2'b01; blen = 8'd20;
        p0 = pulse_seen;
        key_n = 1'b0; cyc(8);
        key_n = 1'b1; cyc(8);
        key_n = 1'b0; cyc(8);
        key_n = 1'b1; cyc(40);
        chk("burst_press_ignored", pulse_seen - p0, 20);

        // Free-run: entry + (run_div+1) edges, then sampled.
        rdiv = 26'd3;
        mode = 2'b10;
        wait_pulse(30, k);
        chk("run_first_latency", k, 6);
        for (int g = 0; g < 3; g++) begin
            wait_pulse(30, k);
            chk("run_gap", k, 4);
        end
        cyc(1);
        mode = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("run_halt_busy", b16.busy, 0);
        p0 = pulse_seen;
        cyc(10);
        chk("run_halt_pulses", pulse_seen - p0, 0);

        rdiv = 26'd0;
        mode = 2'b10;
        wait_pulse(30, k);
        chk("run0_latency", k, 3);
        ones = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            #1;
            ones += int'(b16.cpu_en);
        end
        chk("run0_every_cycle", ones, 5);
        mode = 2'b11;
        cyc(5);

        // Reset in the middle of a long burst.
        mode = 2'b01; blen = 8'd200;
        p0 = pulse_seen;
        key_n = 1'b0;
        k = 0;
        while (pulse_seen - p0 < 10 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("burst_reached_10", (pulse_seen - p0 >= 10) ? 1 : 0, 1);
        @(posedge clk); #2;
        resetn = 1'b0;
        key_n  = 1'b1;
        #1;
        chk("rst_cpu_en", b16.cpu_en, 0);
        chk("rst_count", b16.step_count, 0);
        chk("rst_busy", b16.busy, 0);
        cyc(3);
        resetn = 1'b1;
        p0 = pulse_seen;
        cyc(40);
        chk("after_rst_pulses", pulse_seen - p0, 0);

        // 17 single steps wrap the 4-bit counter to 1.
        mode = 2'b00;
        for (int s = 0; s < 17; s++) begin
            key_n = 1'b0; cyc(8);
            key_n = 1'b1; cyc(10);
        end
        chk("wrap_w4", b4.step_count, 1);
        chk("wrap_w16", b16.step_count, 17);

        // Random mix of modes, lengths, key bounce and resets.
        for (int r = 0; r < 500; r++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) == 0)
                mode = 2'($urandom_range(0, 3));
            blen  = 8'($urandom_range(0, 7));
            rdiv  = 26'($urandom_range(0, 5));
            key_n = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 9));
        end
        key_n = 1'b1;
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
